// File: rtl/flash_nor_par_ctrl.sv
// Parallel NOR flash bus controller: turns single-word valid/ready requests into
// timed CE#/OE#/WE# cycles with optional WAIT-pin stretching and timeout.
module flash_nor_par_ctrl #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int T_SETUP      = 2,
  parameter int T_PULSE      = 8,
  parameter int T_HOLD       = 2,
  parameter int T_TURN       = 2,
  parameter bit WAIT_EN      = 1'b1,
  parameter bit WAIT_POL     = 1'b0,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] flash_addr,
  output logic [DATA_W-1:0] flash_dq_o,
  output logic              flash_dq_oe,
  input  logic [DATA_W-1:0] flash_dq_i,
  input  logic              flash_wait,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n
);

  localparam int T_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int T_MAX_HT = (T_HOLD > T_TURN) ? T_HOLD : T_TURN;
  localparam int T_MAX    = (T_MAX_SP > T_MAX_HT) ? T_MAX_SP : T_MAX_HT;
  localparam int CNT_W    = $clog2(T_MAX + 1);
  localparam int STR_W    = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_RESP  = 3'd4,
    S_TURN  = 3'd5
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [STR_W-1:0]    stretch_r;
  logic                write_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                err_r;
  logic                wait_s1_r;
  logic                wait_s2_r;
  logic                wait_busy_s;

  // Two-flop synchroniser for the asynchronous WAIT pin, reset to "ready".
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_s1_r <= ~WAIT_POL;
      wait_s2_r <= ~WAIT_POL;
    end else begin
      wait_s1_r <= flash_wait;
      wait_s2_r <= wait_s1_r;
    end
  end

  assign wait_busy_s = WAIT_EN && (wait_s2_r == WAIT_POL);

  // Bus-cycle sequencer; every pin and response output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      stretch_r   <= '0;
      write_r     <= 1'b0;
      rdata_r     <= '0;
      err_r       <= 1'b0;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      flash_addr  <= '0;
      flash_dq_o  <= '0;
      flash_dq_oe <= 1'b0;
      flash_ce_n  <= 1'b1;
      flash_oe_n  <= 1'b1;
      flash_we_n  <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready   <= 1'b0;
            state_r     <= S_SETUP;
            cnt_r       <= '0;
            stretch_r   <= '0;
            err_r       <= 1'b0;
            write_r     <= req_write;
            flash_addr  <= req_addr;
            flash_ce_n  <= 1'b0;
            flash_dq_o  <= req_write ? req_wdata : '0;
            flash_dq_oe <= req_write;
          end
        end
        S_SETUP: begin
          if (cnt_r == CNT_W'(T_SETUP - 1)) begin
            state_r    <= S_PULSE;
            cnt_r      <= '0;
            flash_oe_n <= write_r;
            flash_we_n <= ~write_r;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_PULSE: begin
          // On the last nominal pulse cycle a not-ready WAIT holds the strobe low
          // one more cycle, until the stretch counter saturates at the timeout.
          if (cnt_r != CNT_W'(T_PULSE - 1)) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else if (wait_busy_s && (stretch_r != STR_W'(WAIT_TIMEOUT))) begin
            stretch_r <= stretch_r + STR_W'(1);
          end else begin
            state_r    <= S_HOLD;
            cnt_r      <= '0;
            flash_oe_n <= 1'b1;
            flash_we_n <= 1'b1;
            rdata_r    <= write_r ? '0 : flash_dq_i;
            err_r      <= wait_busy_s;
          end
        end
        S_HOLD: begin
          if (cnt_r == CNT_W'(T_HOLD - 1)) begin
            state_r     <= S_RESP;
            cnt_r       <= '0;
            flash_ce_n  <= 1'b1;
            flash_dq_oe <= 1'b0;
            resp_valid  <= 1'b1;
            resp_rdata  <= rdata_r;
            resp_err    <= err_r;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state_r    <= S_TURN;
            cnt_r      <= '0;
          end
        end
        S_TURN: begin
          // Raise req_ready together with the return to IDLE so no cycle is lost.
          if (cnt_r == CNT_W'(T_TURN - 1)) begin
            state_r   <= S_IDLE;
            cnt_r     <= '0;
            req_ready <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r     <= S_IDLE;
          cnt_r       <= '0;
          req_ready   <= 1'b0;
          resp_valid  <= 1'b0;
          flash_dq_oe <= 1'b0;
          flash_ce_n  <= 1'b1;
          flash_oe_n  <= 1'b1;
          flash_we_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_nor_par_ctrl.sv
// Self-checking bench for flash_nor_par_ctrl at default parameters: a flash model
// answers reads, a scoreboard holds expected responses and per-access timing.
module tb_flash_nor_par_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [23:0] req_addr = 24'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [23:0] flash_addr;
  logic [15:0] flash_dq_o;
  logic        flash_dq_oe;
  logic [15:0] flash_dq_i;
  logic        flash_wait = 1'b1;
  logic        flash_ce_n;
  logic        flash_oe_n;
  logic        flash_we_n;
  logic [15:0] model_data = 16'h0;

  flash_nor_par_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .flash_addr(flash_addr), .flash_dq_o(flash_dq_o), .flash_dq_oe(flash_dq_oe),
    .flash_dq_i(flash_dq_i), .flash_wait(flash_wait),
    .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n), .flash_we_n(flash_we_n)
  );

  always #5 clk = ~clk;

  // Flash device model: drives its data only while output-enabled.
  assign flash_dq_i = flash_oe_n ? 16'h0000 : model_data;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          oe_last;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_fail   = 0;

  int          obs_oe_first, obs_oe_last, obs_we_first, obs_we_last;
  int          obs_doe_first, obs_doe_last, obs_resp_cyc, obs_ready_cyc;
  logic [15:0] obs_rdata, obs_dq_o;
  logic [23:0] obs_addr;
  logic        obs_err, obs_unstable, obs_both_low, obs_ready_early, obs_ce_bad;

  // Drives one request at a negedge (cycle 0 = handshake cycle) and records what
  // the bus and response ports do each following cycle until req_ready returns.
  task automatic run_access(input logic wr, input logic [23:0] addr, input logic [15:0] wd,
                            input int wlo, input int whi, input int hold, input int budget);
    int  n = 0;
    bit  done = 0;
    bit  resp_done = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    obs_oe_first = -1; obs_oe_last = -1; obs_we_first = -1; obs_we_last = -1;
    obs_doe_first = -1; obs_doe_last = -1; obs_resp_cyc = -1; obs_ready_cyc = -1;
    obs_rdata = 16'hxxxx; obs_dq_o = 16'hxxxx; obs_addr = 24'hxxxxxx; obs_err = 1'bx;
    obs_unstable = 1'b0; obs_both_low = 1'b0; obs_ready_early = 1'b0; obs_ce_bad = 1'b0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    resp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= budget && !done; k++) begin
      if (k > 1) @(negedge clk);
      flash_wait = (k >= wlo && k <= whi) ? 1'b0 : 1'b1;
      if (k == 1) obs_addr = flash_addr;
      if (!flash_oe_n) begin
        if (obs_oe_first < 0) obs_oe_first = k;
        obs_oe_last = k;
      end
      if (!flash_we_n) begin
        if (obs_we_first < 0) obs_we_first = k;
        obs_we_last = k;
      end
      if (flash_dq_oe) begin
        if (obs_doe_first < 0) obs_doe_first = k;
        obs_doe_last = k;
        obs_dq_o = flash_dq_o;
      end
      if (!flash_oe_n && !flash_we_n) obs_both_low = 1'b1;
      if (req_ready) begin
        if (resp_done) begin
          obs_ready_cyc = k;
          done = 1;
        end else begin
          obs_ready_early = 1'b1;
        end
      end
      if (resp_valid) begin
        if (!flash_ce_n) obs_ce_bad = 1'b1;
        if (obs_resp_cyc < 0) begin
          obs_resp_cyc = k;
          obs_rdata = resp_rdata;
          obs_err = resp_err;
        end else if (resp_rdata !== obs_rdata || resp_err !== obs_err) begin
          obs_unstable = 1'b1;
        end
        if (hold > 0 && k >= obs_resp_cyc + hold) resp_ready = 1'b1;
        if (resp_ready) resp_done = 1;
      end
    end
    flash_wait = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({req_ready, resp_valid, resp_err, flash_dq_oe} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl got %b exp 0000", {req_ready, resp_valid, resp_err, flash_dq_oe}); end
    n_checks++; if ({flash_ce_n, flash_oe_n, flash_we_n} !== 3'b111) begin n_fail++; $display("FAIL reset_strobes got %b exp 111", {flash_ce_n, flash_oe_n, flash_we_n}); end
    n_checks++; if ({resp_rdata, flash_addr, flash_dq_o} !== 56'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", {resp_rdata, flash_addr, flash_dq_o}); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise got %b exp 1", req_ready); end
  endtask

  task automatic test_read();
    model_data = 16'hBEEF;
    sb.push_back('{rdata: 16'hBEEF, err: 1'b0, lat: 13, oe_last: 10});
    run_access(1'b0, 24'h123456, 16'h0, 0, -1, 0, 60);
    e = sb.pop_front();
    n_checks++; if (obs_resp_cyc !== e.lat) begin n_fail++; $display("FAIL rd_latency got %0d exp %0d", obs_resp_cyc, e.lat); end
    n_checks++; if (obs_rdata !== e.rdata || obs_err !== e.err) begin n_fail++; $display("FAIL rd_resp got %h/%b exp %h/%b", obs_rdata, obs_err, e.rdata, e.err); end
    n_checks++; if (obs_oe_first !== 3 || obs_oe_last !== e.oe_last) begin n_fail++; $display("FAIL rd_oe_window got %0d..%0d exp 3..%0d", obs_oe_first, obs_oe_last, e.oe_last); end
    n_checks++; if (obs_we_first !== -1 || obs_doe_first !== -1) begin n_fail++; $display("FAIL rd_no_we_doe got we %0d doe %0d exp -1 -1", obs_we_first, obs_doe_first); end
    n_checks++; if (obs_addr !== 24'h123456) begin n_fail++; $display("FAIL rd_addr got %h exp 123456", obs_addr); end
    n_checks++; if (obs_ready_cyc !== 16) begin n_fail++; $display("FAIL rd_ready_return got %0d exp 16", obs_ready_cyc); end
  endtask

  task automatic test_write();
    model_data = 16'hFFFF;
    sb.push_back('{rdata: 16'h0000, err: 1'b0, lat: 13, oe_last: -1});
    run_access(1'b1, 24'h00ABCD, 16'h5A5A, 0, -1, 0, 60);
    e = sb.pop_front();
    n_checks++; if (obs_resp_cyc !== e.lat) begin n_fail++; $display("FAIL wr_latency got %0d exp %0d", obs_resp_cyc, e.lat); end
    n_checks++; if (obs_rdata !== e.rdata || obs_err !== e.err) begin n_fail++; $display("FAIL wr_resp got %h/%b exp %h/%b", obs_rdata, obs_err, e.rdata, e.err); end
    n_checks++; if (obs_we_first !== 3 || obs_we_last !== 10) begin n_fail++; $display("FAIL wr_we_window got %0d..%0d exp 3..10", obs_we_first, obs_we_last); end
    n_checks++; if (obs_doe_first !== 1 || obs_doe_last !== 12) begin n_fail++; $display("FAIL wr_doe_window got %0d..%0d exp 1..12", obs_doe_first, obs_doe_last); end
    n_checks++; if (obs_dq_o !== 16'h5A5A || obs_addr !== 24'h00ABCD) begin n_fail++; $display("FAIL wr_dq_addr got %h@%h exp 5a5a@00abcd", obs_dq_o, obs_addr); end
    n_checks++; if (obs_oe_last !== e.oe_last || obs_both_low !== 1'b0) begin n_fail++; $display("FAIL wr_no_oe got oe %0d both %b exp -1 0", obs_oe_last, obs_both_low); end
  endtask

  task automatic test_wait_stretch();
    model_data = 16'h1357;
    sb.push_back('{rdata: 16'h1357, err: 1'b0, lat: 18, oe_last: 15});
    // Pin low in cycles 8..12 appears at the synchroniser output in cycles 10..14.
    run_access(1'b0, 24'h000010, 16'h0, 8, 12, 0, 60);
    e = sb.pop_front();
    n_checks++; if (obs_oe_first !== 3 || obs_oe_last !== e.oe_last) begin n_fail++; $display("FAIL wait_oe_window got %0d..%0d exp 3..%0d", obs_oe_first, obs_oe_last, e.oe_last); end
    n_checks++; if (obs_resp_cyc !== e.lat) begin n_fail++; $display("FAIL wait_latency got %0d exp %0d", obs_resp_cyc, e.lat); end
    n_checks++; if (obs_rdata !== e.rdata || obs_err !== e.err) begin n_fail++; $display("FAIL wait_resp got %h/%b exp %h/%b", obs_rdata, obs_err, e.rdata, e.err); end
  endtask

  task automatic test_wait_outside_pulse();
    model_data = 16'h0F0F;
    sb.push_back('{rdata: 16'h0F0F, err: 1'b0, lat: 13, oe_last: 10});
    run_access(1'b0, 24'h000020, 16'h0, 1, 6, 0, 60);
    e = sb.pop_front();
    n_checks++; if (obs_resp_cyc !== e.lat || obs_oe_last !== e.oe_last) begin n_fail++; $display("FAIL wait_ignored got resp %0d oe_last %0d exp %0d %0d", obs_resp_cyc, obs_oe_last, e.lat, e.oe_last); end
  endtask

  task automatic test_wait_timeout();
    model_data = 16'h2468;
    sb.push_back('{rdata: 16'h2468, err: 1'b1, lat: 268, oe_last: 265});
    run_access(1'b0, 24'h000030, 16'h0, 1, 100000, 0, 400);
    e = sb.pop_front();
    n_checks++; if (obs_oe_first !== 3 || obs_oe_last !== e.oe_last) begin n_fail++; $display("FAIL tmo_oe_window got %0d..%0d exp 3..%0d", obs_oe_first, obs_oe_last, e.oe_last); end
    n_checks++; if (obs_resp_cyc !== e.lat) begin n_fail++; $display("FAIL tmo_latency got %0d exp %0d", obs_resp_cyc, e.lat); end
    n_checks++; if (obs_err !== e.err || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL tmo_resp got %h/%b exp %h/%b", obs_rdata, obs_err, e.rdata, e.err); end
    n_checks++; if (obs_ce_bad !== 1'b0 || obs_ready_cyc !== 271) begin n_fail++; $display("FAIL tmo_bus_release got ce_bad %b ready %0d exp 0 271", obs_ce_bad, obs_ready_cyc); end
  endtask

  task automatic test_resp_backpressure();
    model_data = 16'hC0DE;
    sb.push_back('{rdata: 16'hC0DE, err: 1'b0, lat: 13, oe_last: 10});
    run_access(1'b0, 24'h000040, 16'h0, 0, -1, 10, 80);
    e = sb.pop_front();
    n_checks++; if (obs_resp_cyc !== e.lat || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL bp_resp got %0d/%h exp %0d/%h", obs_resp_cyc, obs_rdata, e.lat, e.rdata); end
    n_checks++; if (obs_unstable !== 1'b0 || obs_ready_early !== 1'b0) begin n_fail++; $display("FAIL bp_stable got unstable %b ready_early %b exp 0 0", obs_unstable, obs_ready_early); end
    n_checks++; if (obs_ready_cyc !== 26) begin n_fail++; $display("FAIL bp_ready_return got %0d exp 26", obs_ready_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [2];
    vals[0] = 16'h1111;
    vals[1] = 16'hA55A;
    for (int i = 0; i < 2; i++) begin
      model_data = vals[i];
      sb.push_back('{rdata: vals[i], err: 1'b0, lat: 13, oe_last: 10});
      run_access(1'b0, 24'h000100 + 24'(i), 16'h0, 0, -1, 0, 60);
      e = sb.pop_front();
      n_checks++; if (obs_resp_cyc !== e.lat || obs_rdata !== e.rdata) begin n_fail++; $display("FAIL b2b_resp%0d got %0d/%h exp %0d/%h", i, obs_resp_cyc, obs_rdata, e.lat, e.rdata); end
      n_checks++; if (obs_ready_cyc !== 16) begin n_fail++; $display("FAIL b2b_period%0d got %0d exp 16", i, obs_ready_cyc); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n = 0;
    int seen_resp = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    model_data = 16'h7777;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000200; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (flash_oe_n !== 1'b0) begin n_fail++; $display("FAIL mid_in_pulse got oe_n %b exp 0", flash_oe_n); end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({flash_ce_n, flash_oe_n, flash_we_n, flash_dq_oe, resp_valid} !== 5'b11100) begin n_fail++; $display("FAIL mid_reset_bus got %b exp 11100", {flash_ce_n, flash_oe_n, flash_we_n, flash_dq_oe, resp_valid}); end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_rise got %b exp 1", req_ready); end
    for (int k = 0; k < 40; k++) begin
      if (resp_valid) seen_resp++;
      @(negedge clk);
    end
    n_checks++; if (seen_resp !== 0) begin n_fail++; $display("FAIL mid_no_resp got %0d exp 0", seen_resp); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wait_stretch();
    test_wait_outside_pulse();
    test_wait_timeout();
    test_resp_backpressure();
    test_back_to_back();
    test_reset_mid_pulse();
    n_checks++; if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_drained got %0d exp 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
